matrix_tile_streamer: RTL and testbench

Producer-side adapter for the tiled matrix stream consumed by `matmul` and `simple_matmul`. It accepts a matrix as a row-major stream of `COMPUTE_DIM0`-wide row chunks. It buffers one strip of `COMPUTE_DIM1` rows, then emits that strip as `COMPUTE_DIM1 x COMPUTE_DIM0` sub-blocks, walking along dim0 first. It sits between row-streaming sources (memory readers, activation layers) and the matmul A/B ports.

---
 rtl/matrix_stream_pkg.sv | 14 +
 rtl/matrix_tile_streamer_if.sv | 24 ++
 rtl/matrix_strip_buffer.sv | 48 ++++
 rtl/matrix_tile_streamer.sv | 125 ++++++++++++
 tb/tb_matrix_tile_streamer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the tiled matrix stream blocks.
package matrix_stream_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } tile_stream_state_t;

    // Pointer width for a counter over n positions; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_tile_streamer_if.sv
// Row-chunk input stream and tile output stream of matrix_tile_streamer.
interface matrix_tile_streamer_if #(
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2,
    parameter int DATA_WIDTH   = 8
);
    logic [COMPUTE_DIM0-1:0][DATA_WIDTH-1:0]              in_data;
    logic                                                 in_valid;
    logic                                                 in_ready;
    logic [COMPUTE_DIM0*COMPUTE_DIM1-1:0][DATA_WIDTH-1:0] out_data;
    logic                                                 out_valid;
    logic                                                 out_ready;
    logic                                                 out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/matrix_strip_buffer.sv
// One strip of rows held as ROWS x COLS words; written one word per cycle,
// read one tile column (all rows at one word index) at a time.
module matrix_strip_buffer #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int WORD_W = 16,
    parameter int ROW_W  = 1,
    parameter int COL_W  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [ROW_W-1:0]             wr_row_i,
    input  logic [COL_W-1:0]             wr_col_i,
    input  logic [WORD_W-1:0]            wr_data_i,
    input  logic [COL_W-1:0]             rd_col_i,
    output logic [ROWS-1:0][WORD_W-1:0]  rd_tile_o
);

    logic [ROWS-1:0][COLS-1:0][WORD_W-1:0] mem_q;

    // Address decode by comparison keeps pointer widths independent of array size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (wr_row_i == ROW_W'(r) && wr_col_i == COL_W'(c)) begin
                        mem_q[r][c] <= wr_data_i;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_tile_o = '0;
        for (int c = 0; c < COLS; c++) begin
            if (rd_col_i == COL_W'(c)) begin
                for (int r = 0; r < ROWS; r++) begin
                    rd_tile_o[r] = mem_q[r][c];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_tile_streamer.sv
// Buffers one strip of COMPUTE_DIM1 row-major rows, then replays it as
// COMPUTE_DIM1 x COMPUTE_DIM0 tiles walking along dim0.
module matrix_tile_streamer
    import matrix_stream_pkg::*;
#(
    parameter int TOTAL_DIM0   = 4,
    parameter int TOTAL_DIM1   = 4,
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    matrix_tile_streamer_if.slave         strm_io
);

    localparam int DEPTH_DIM0 = TOTAL_DIM0 / COMPUTE_DIM0;
    localparam int DEPTH_DIM1 = TOTAL_DIM1 / COMPUTE_DIM1;
    localparam int COL_W      = ptr_width(DEPTH_DIM0);
    localparam int ROW_W      = ptr_width(COMPUTE_DIM1);
    localparam int STRIP_W    = ptr_width(DEPTH_DIM1);
    localparam int WORD_W     = COMPUTE_DIM0 * DATA_WIDTH;

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(DEPTH_DIM0 - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(COMPUTE_DIM1 - 1);
    localparam logic [STRIP_W-1:0] STRIP_LAST = STRIP_W'(DEPTH_DIM1 - 1);

    if ((TOTAL_DIM0 % COMPUTE_DIM0) != 0) begin : g_bad_dim0
        $fatal(1, "TOTAL_DIM0 must be a multiple of COMPUTE_DIM0");
    end
    if ((TOTAL_DIM1 % COMPUTE_DIM1) != 0) begin : g_bad_dim1
        $fatal(1, "TOTAL_DIM1 must be a multiple of COMPUTE_DIM1");
    end

    tile_stream_state_t state_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   tile_q;
    logic [STRIP_W-1:0] strip_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               out_last_q;

    logic in_hs;
    logic out_hs;
    logic [COMPUTE_DIM1-1:0][WORD_W-1:0] rd_tile;

    assign in_hs  = strm_io.in_valid && in_ready_q;
    assign out_hs = out_valid_q && strm_io.out_ready;

    // Handshake outputs are flops so neither side sees a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            row_q       <= '0;
            col_q       <= '0;
            tile_q      <= '0;
            strip_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_hs) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q       <= '0;
                                state_q     <= DRAIN;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                                out_last_q  <= (COL_LAST == '0) && (strip_q == STRIP_LAST);
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (tile_q == COL_LAST) begin
                            tile_q      <= '0;
                            strip_q     <= (strip_q == STRIP_LAST) ? '0 : strip_q + STRIP_W'(1);
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            tile_q     <= tile_q + COL_W'(1);
                            out_last_q <= (tile_q + COL_W'(1) == COL_LAST) && (strip_q == STRIP_LAST);
                        end
                    end
                end
            endcase
        end
    end

    matrix_strip_buffer #(
        .ROWS   (COMPUTE_DIM1),
        .COLS   (DEPTH_DIM0),
        .WORD_W (WORD_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_strip (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (in_hs),
        .wr_row_i  (row_q),
        .wr_col_i  (col_q),
        .wr_data_i (strm_io.in_data),
        .rd_col_i  (tile_q),
        .rd_tile_o (rd_tile)
    );

    // Row r of the tile lands at out_data[r*COMPUTE_DIM0 +: COMPUTE_DIM0],
    // which is exactly the packed word order of the buffer read.
    assign strm_io.out_data  = rd_tile;
    assign strm_io.in_ready  = in_ready_q;
    assign strm_io.out_valid = out_valid_q;
    assign strm_io.out_last  = out_last_q;

endmodule

// File: tb/tb_matrix_tile_streamer.sv
// Bench for matrix_tile_streamer: matrix-level tile model plus directed
// scenarios on the default 4x4/2x2 instance and a 2x2/2x1 instance.
module tb_matrix_tile_streamer;

    localparam int TD0 = 4;
    localparam int TD1 = 4;
    localparam int CD0 = 2;
    localparam int CD1 = 2;
    localparam int D0  = TD0 / CD0;
    localparam int D1  = TD1 / CD1;

    typedef logic [CD0*CD1-1:0][7:0] tile_t;
    typedef struct packed {
        tile_t data;
        logic  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    matrix_tile_streamer_if #(.COMPUTE_DIM0(CD0), .COMPUTE_DIM1(CD1), .DATA_WIDTH(8)) bus ();
    matrix_tile_streamer_if #(.COMPUTE_DIM0(2), .COMPUTE_DIM1(1), .DATA_WIDTH(8)) dbus ();

    matrix_tile_streamer #(
        .TOTAL_DIM0(TD0), .TOTAL_DIM1(TD1), .COMPUTE_DIM0(CD0), .COMPUTE_DIM1(CD1), .DATA_WIDTH(8)
    ) dut (.clk(clk), .rst(rst), .strm_io(bus));

    matrix_tile_streamer #(
        .TOTAL_DIM0(2), .TOTAL_DIM1(2), .COMPUTE_DIM0(2), .COMPUTE_DIM1(1), .DATA_WIDTH(8)
    ) dut_d (.clk(clk), .rst(rst), .strm_io(dbus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tile_t mk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Model: collect a strip of beats, then expect its tiles in dim0 order.
    exp_t       exp_q[$];
    exp_t       seen_q[$];
    logic [7:0] m_buf [CD1][TD0];
    int         m_beats = 0;
    int         m_strip = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_last", bus.out_last, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_d_in_ready", dbus.in_ready, 1);
            chk("rst_d_out_valid", dbus.out_valid, 0);
            exp_q.delete();
            m_beats = 0;
            m_strip = 0;
        end else begin
            chk("in_ready", bus.in_ready, exp_q.size() == 0);
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("out_data", bus.out_data, exp_q[0].data);
                chk("out_last", bus.out_last, exp_q[0].last);
            end
            if (bus.out_valid && bus.out_ready) begin
                e.data = bus.out_data;
                e.last = bus.out_last;
                seen_q.push_back(e);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int j = 0; j < CD0; j++)
                    m_buf[m_beats / D0][(m_beats % D0) * CD0 + j] = bus.in_data[j];
                m_beats++;
                if (m_beats == CD1 * D0) begin
                    m_beats = 0;
                    for (int t = 0; t < D0; t++) begin
                        for (int r = 0; r < CD1; r++)
                            for (int c = 0; c < CD0; c++)
                                e.data[r*CD0+c] = m_buf[r][t*CD0+c];
                        e.last = (m_strip == D1 - 1) && (t == D0 - 1);
                        exp_q.push_back(e);
                    end
                    m_strip = (m_strip + 1) % D1;
                end
            end
        end
    end

    // Drives one beat (with an optional idle gap before it); returns #1 after
    // the accepting edge.
    task automatic send_beat(input int a, input int b, input int gap);
        int n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_data  = {8'(b), 8'(a)};
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) begin
            chk("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rows(input int base, input int r0, input int r1, input int maxgap);
        for (int r = r0; r <= r1; r++)
            for (int ch = 0; ch < D0; ch++)
                send_beat(base + r*TD0 + ch*CD0, base + r*TD0 + ch*CD0 + 1,
                          (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin @(posedge clk); #1; n++; end
        chk({name, "_drain"}, n < 300, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_in_ready", bus.in_ready, 1);
        chk("async_rst_out_data", bus.out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        dbus.in_valid  = 1'b0;
        dbus.in_data   = '0;
        dbus.out_ready = 1'b0;
        do_reset();

        // Basic stream with latency checks around the first strip.
        seen_q.delete();
        bus.out_ready = 1'b1;
        send_rows(0, 0, 1, 0);
        chk("lat_first_tile_valid", bus.out_valid, 1);
        chk("lat_fill_ready_low", bus.in_ready, 0);
        chk("lat_first_tile_data", bus.out_data, mk(0, 1, 4, 5));
        @(posedge clk); #1;
        chk("lat_second_tile_data", bus.out_data, mk(2, 3, 6, 7));
        chk("lat_drain_ready_low", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("lat_ready_after_drain", bus.in_ready, 1);
        chk("lat_valid_after_drain", bus.out_valid, 0);
        send_rows(0, 2, 3, 0);
        wait_drain("basic");
        chk("basic_count", seen_q.size(), 4);
        if (seen_q.size() == 4) begin
            chk("basic_t0", seen_q[0].data, mk(0, 1, 4, 5));
            chk("basic_t1", seen_q[1].data, mk(2, 3, 6, 7));
            chk("basic_t2", seen_q[2].data, mk(8, 9, 12, 13));
            chk("basic_t3", seen_q[3].data, mk(10, 11, 14, 15));
            chk("basic_last", {seen_q[0].last, seen_q[1].last, seen_q[2].last, seen_q[3].last}, 4'b0001);
        end

        // Backpressure on the second tile of a strip.
        seen_q.delete();
        bus.out_ready = 1'b0;
        send_rows(0, 0, 1, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_data_stable", bus.out_data, mk(2, 3, 6, 7));
            chk("bp_valid_stable", bus.out_valid, 1);
            chk("bp_in_ready_low", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send_rows(0, 2, 3, 0);
        wait_drain("bp");
        chk("bp_count", seen_q.size(), 4);
        if (seen_q.size() == 4) chk("bp_t1", seen_q[1].data, mk(2, 3, 6, 7));

        // Input bubbles, two matrices back-to-back.
        seen_q.delete();
        send_rows(0, 0, 3, 3);
        send_rows(100, 0, 3, 3);
        wait_drain("b2b");
        chk("b2b_count", seen_q.size(), 8);
        if (seen_q.size() == 8) begin
            chk("b2b_t4", seen_q[4].data, mk(100, 101, 104, 105));
            chk("b2b_t7", seen_q[7].data, mk(110, 111, 114, 115));
            chk("b2b_last", {seen_q[0].last, seen_q[1].last, seen_q[2].last, seen_q[3].last,
                             seen_q[4].last, seen_q[5].last, seen_q[6].last, seen_q[7].last}, 8'b00010001);
        end

        // Reset mid-drain, then a fresh matrix.
        bus.out_ready = 1'b0;
        send_rows(50, 0, 1, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        do_reset();
        seen_q.delete();
        bus.out_ready = 1'b1;
        send_rows(0, 0, 3, 0);
        wait_drain("rst");
        chk("rst_count", seen_q.size(), 4);
        if (seen_q.size() != 0) chk("rst_first_tile", seen_q[0].data, mk(0, 1, 4, 5));

        // Degenerate config: each beat is a whole tile.
        @(posedge clk); #1;
        dbus.out_ready = 1'b1;
        dbus.in_data   = {8'd9, 8'd7};
        dbus.in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("deg_t0_valid", dbus.out_valid, 1);
        chk("deg_t0_in_ready", dbus.in_ready, 0);
        chk("deg_t0_data", dbus.out_data, 16'h0907);
        chk("deg_t0_last", dbus.out_last, 0);
        dbus.in_data = {8'd5, 8'd3};
        @(posedge clk); #1;
        chk("deg_fill_in_ready", dbus.in_ready, 1);
        chk("deg_fill_valid", dbus.out_valid, 0);
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        chk("deg_t1_valid", dbus.out_valid, 1);
        chk("deg_t1_data", dbus.out_data, 16'h0503);
        chk("deg_t1_last", dbus.out_last, 1);
        @(posedge clk); #1;
        chk("deg_end_valid", dbus.out_valid, 0);
        chk("deg_end_last", dbus.out_last, 0);
        chk("deg_end_in_ready", dbus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
